// File: rtl/traffic_pkg.sv
// Shared lane indices, phase encoding and default timing for the intersection controller.
package traffic_pkg;

    localparam logic [1:0] LANE_NS1 = 2'd0;
    localparam logic [1:0] LANE_NS2 = 2'd1;
    localparam logic [1:0] LANE_EW1 = 2'd2;
    localparam logic [1:0] LANE_EW2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } phase_e;

    localparam int unsigned GREEN_MIN_DEF   = 8;
    localparam int unsigned GREEN_EXT_DEF   = 4;
    localparam int unsigned GREEN_MAX_DEF   = 20;
    localparam int unsigned YELLOW_TIME_DEF = 3;
    localparam int unsigned ALLRED_TIME_DEF = 1;
    localparam int unsigned CNT_W_DEF       = 8;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// Round-robin lane search: first requesting lane after last, with last itself checked last.
module rr_lane_picker (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] lane
);

    logic [1:0] cand;

    // Walk from the lowest priority (last) up to last+1 so the highest priority wins.
    always_comb begin
        valid = 1'b0;
        lane  = last;
        cand  = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) begin
                valid = 1'b1;
                lane  = cand;
            end
        end
    end

endmodule

// File: rtl/lane_phase_scheduler.sv
// Demand-driven round-robin green/yellow/all-red sequencer for four lanes.
// Optional PREEMPT_EN adds preempt/preempt_lane priority override.
module lane_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN   = GREEN_MIN_DEF,
    parameter int unsigned GREEN_EXT   = GREEN_EXT_DEF,
    parameter int unsigned GREEN_MAX   = GREEN_MAX_DEF,
    parameter int unsigned YELLOW_TIME = YELLOW_TIME_DEF,
    parameter int unsigned ALLRED_TIME = ALLRED_TIME_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic [3:0] cong,
`ifdef PREEMPT_EN
    input  logic       preempt,
    input  logic [1:0] preempt_lane,
`endif
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic       all_red,
    output logic [1:0] active_lane,
    output logic [1:0] phase,
    output logic       phase_done
);

    localparam int unsigned XW = CNT_W + 1;

    phase_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, limit, limit_nxt;
    logic [1:0]       lane_nxt;
    logic             resting, resting_nxt, done_nxt;
    logic [3:0]       green_nxt, yellow_nxt;
    logic             all_red_nxt;

    logic             pick_valid;
    logic [1:0]       pick_lane;
    logic [XW-1:0]    cnt_inc, limit_ext;
    logic             at_limit, can_ext, other_req;
    logic             pre_act;
    logic [1:0]       pre_lane;

`ifdef PREEMPT_EN
    assign pre_act  = preempt;
    assign pre_lane = preempt_lane;
`else
    assign pre_act  = 1'b0;
    assign pre_lane = 2'd0;
`endif

    rr_lane_picker u_picker (
        .req   (req),
        .last  (active_lane),
        .valid (pick_valid),
        .lane  (pick_lane)
    );

    // One extra bit keeps the limit comparisons from wrapping.
    assign cnt_inc   = XW'(cnt) + XW'(1);
    assign limit_ext = XW'(limit) + XW'(GREEN_EXT);
    assign at_limit  = (cnt_inc == XW'(limit));
    assign can_ext   = cong[active_lane] && (limit_ext <= XW'(GREEN_MAX));
    assign other_req = |(req & ~lane_onehot(active_lane));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        limit_nxt   = limit;
        lane_nxt    = active_lane;
        resting_nxt = resting;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (pre_act || pick_valid) begin
                    state_nxt   = GREEN;
                    lane_nxt    = pre_act ? pre_lane : pick_lane;
                    cnt_nxt     = '0;
                    limit_nxt   = CNT_W'(GREEN_MIN);
                    resting_nxt = 1'b0;
                end
            end
            GREEN: begin
                if (pre_act && (active_lane != pre_lane)) begin
                    state_nxt   = YELLOW;
                    cnt_nxt     = '0;
                    resting_nxt = 1'b0;
                end else if (pre_act) begin
                    // Preempted hold: count up but never reach the limit event.
                    if (tick && !at_limit) cnt_nxt = cnt_inc[CNT_W-1:0];
                end else if (tick && at_limit) begin
                    if (can_ext) begin
                        limit_nxt   = limit_ext[CNT_W-1:0];
                        cnt_nxt     = cnt_inc[CNT_W-1:0];
                        resting_nxt = 1'b0;
                    end else if (other_req) begin
                        state_nxt   = YELLOW;
                        cnt_nxt     = '0;
                        resting_nxt = 1'b0;
                    end else begin
                        resting_nxt = 1'b1;
                    end
                end else if (resting && other_req) begin
                    state_nxt   = YELLOW;
                    cnt_nxt     = '0;
                    resting_nxt = 1'b0;
                end else if (tick) begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                end
            end
            YELLOW: begin
                if (tick) begin
                    if (cnt_inc == XW'(YELLOW_TIME)) begin
                        state_nxt = ALLRED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            ALLRED: begin
                if (tick) begin
                    if (cnt_inc == XW'(ALLRED_TIME)) begin
                        done_nxt    = 1'b1;
                        cnt_nxt     = '0;
                        limit_nxt   = CNT_W'(GREEN_MIN);
                        resting_nxt = 1'b0;
                        if (pre_act || pick_valid) begin
                            state_nxt = GREEN;
                            lane_nxt  = pre_act ? pre_lane : pick_lane;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        green_nxt   = (state_nxt == GREEN)  ? lane_onehot(lane_nxt) : 4'b0000;
        yellow_nxt  = (state_nxt == YELLOW) ? lane_onehot(lane_nxt) : 4'b0000;
        all_red_nxt = (state_nxt != GREEN) && (state_nxt != YELLOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            limit       <= CNT_W'(GREEN_MIN);
            active_lane <= LANE_EW2;
            resting     <= 1'b0;
            green       <= 4'b0000;
            yellow      <= 4'b0000;
            all_red     <= 1'b1;
            phase_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            limit       <= limit_nxt;
            active_lane <= lane_nxt;
            resting     <= resting_nxt;
            green       <= green_nxt;
            yellow      <= yellow_nxt;
            all_red     <= all_red_nxt;
            phase_done  <= done_nxt;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Directed scoreboard bench for lane_phase_scheduler; PREEMPT_EN enables the preemption scenario.
module tb_lane_phase_scheduler;
    import traffic_pkg::*;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] len;   // 0 = green length not checked (rest or preempted)
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] cong = 4'b0000;
`ifdef PREEMPT_EN
    logic       preempt = 1'b0;
    logic [1:0] preempt_lane = 2'd0;
`endif
    logic [3:0] green, yellow;
    logic       all_red, phase_done;
    logic [1:0] active_lane, phase;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur = '0;
    int   glen = 0;
    int   ylen = 0;
    logic [3:0] prev_green = 4'b0000;
    logic [3:0] prev_yellow = 4'b0000;
    logic [1:0] prev_phase = 2'd0;

    lane_phase_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .req          (req),
        .cong         (cong),
`ifdef PREEMPT_EN
        .preempt      (preempt),
        .preempt_lane (preempt_lane),
`endif
        .green        (green),
        .yellow       (yellow),
        .all_red      (all_red),
        .active_lane  (active_lane),
        .phase        (phase),
        .phase_done   (phase_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle and run the per-cycle monitor/scoreboard at the falling edge.
    task automatic step();
        @(negedge clk);
        chk("onehot", 32'({$onehot0(green), $onehot0(yellow), ~((|green) & (|yellow))}), 32'(3'b111));
        chk("all_red", 32'(all_red), 32'((green == 4'b0) && (yellow == 4'b0)));
        chk("phase_done", 32'(phase_done), 32'((prev_phase == 2'd3) && (phase != 2'd3) && !rst));
        if (green !== 4'b0 && prev_green === 4'b0) begin
            chk("green_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("green_lane", 32'({active_lane, green}), 32'({cur.lane, lane_onehot(cur.lane)}));
            end else begin
                cur = '0;
            end
            glen = 0;
        end
        if (green !== 4'b0) glen++;
        if (green === 4'b0 && prev_green !== 4'b0 && phase === 2'd2 && cur.len != 8'd0)
            chk("green_len", 32'(glen), 32'(cur.len));
        if (yellow !== 4'b0 && prev_yellow === 4'b0) ylen = 0;
        if (yellow !== 4'b0) ylen++;
        if (yellow === 4'b0 && prev_yellow !== 4'b0 && phase === 2'd3)
            chk("yellow_len", 32'(ylen), 32'(3));
        prev_green  = green;
        prev_yellow = yellow;
        prev_phase  = phase;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_grant(input logic is_yellow, input logic [3:0] g, input int bound, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (((is_yellow ? yellow : green) !== g) && n < bound);
        chk(tag, 32'(is_yellow ? yellow : green), 32'(g));
    endtask

    initial begin
        // Reset state
        steps(3);
        chk("rst_phase", 32'(phase), 32'(0));
        chk("rst_grants", 32'({green, yellow}), 32'(0));
        chk("rst_all_red", 32'(all_red), 32'(1));
        chk("rst_active", 32'(active_lane), 32'(3));
        chk("rst_done", 32'(phase_done), 32'(0));

        // Single requester: immediate green, then rest
        rst = 1'b0;
        exp_q.push_back('{lane: 2'd0, len: 8'd0});
        req = 4'b0001;
        step();
        chk("t1_green", 32'(green), 32'(4'b0001));
        chk("t1_phase", 32'(phase), 32'(1));
        steps(25);
        chk("t1_rest_green", 32'(green), 32'(4'b0001));
        chk("t1_rest_yellow", 32'(yellow), 32'(0));

        // Two requesters alternate 0 -> 2 -> 0 -> 2
        exp_q.push_back('{lane: 2'd2, len: 8'd8});
        exp_q.push_back('{lane: 2'd0, len: 8'd8});
        exp_q.push_back('{lane: 2'd2, len: 8'd8});
        req = 4'b0101;
        step();
        chk("t2_rest_exit", 32'({phase, yellow}), 32'({2'd2, 4'b0001}));
        wait_grant(1'b0, 4'b0100, 20, "t2_lane2a");
        wait_grant(1'b0, 4'b0001, 20, "t2_lane0");
        wait_grant(1'b0, 4'b0100, 20, "t2_lane2b");

        // Congestion extension capped at GREEN_MAX
        req  = 4'b0011;
        cong = 4'b0001;
        exp_q.push_back('{lane: 2'd0, len: 8'd20});
        exp_q.push_back('{lane: 2'd1, len: 8'd8});
        wait_grant(1'b0, 4'b0010, 60, "t3_lane1");

        // All lanes: round robin continues 2,3,0,1
        req  = 4'b1111;
        cong = 4'b0000;
        exp_q.push_back('{lane: 2'd2, len: 8'd8});
        exp_q.push_back('{lane: 2'd3, len: 8'd8});
        exp_q.push_back('{lane: 2'd0, len: 8'd8});
        exp_q.push_back('{lane: 2'd1, len: 8'd8});
        wait_grant(1'b0, 4'b0100, 20, "t4_lane2");
        wait_grant(1'b0, 4'b1000, 20, "t4_lane3");
        wait_grant(1'b0, 4'b0001, 20, "t4_lane0");
        wait_grant(1'b0, 4'b0010, 20, "t4_lane1");
        wait_grant(1'b1, 4'b0010, 20, "t4_yellow1");

        // Reset during yellow
        rst = 1'b1;
        req = 4'b1000;
        step();
        chk("t5_phase", 32'(phase), 32'(0));
        chk("t5_grants", 32'({green, yellow}), 32'(0));
        chk("t5_all_red", 32'(all_red), 32'(1));
        chk("t5_active", 32'(active_lane), 32'(3));
        rst = 1'b0;
        exp_q.push_back('{lane: 2'd3, len: 8'd0});
        step();
        chk("t5_green", 32'({active_lane, green}), 32'({2'd3, 4'b1000}));
        steps(3);

`ifdef PREEMPT_EN
        // Preemption to lane 2 while lane 3 is green
        preempt      = 1'b1;
        preempt_lane = 2'd2;
        exp_q.push_back('{lane: 2'd2, len: 8'd0});
        step();
        chk("t6_yellow", 32'(yellow), 32'(4'b1000));
        wait_grant(1'b0, 4'b0100, 10, "t6_lane2");
        steps(30);
        chk("t6_hold", 32'(green), 32'(4'b0100));
        preempt = 1'b0;
        req     = 4'b0100;
        steps(15);
        chk("t6_release", 32'(green), 32'(4'b0100));
`else
        steps(15);
        chk("t5_rest", 32'(green), 32'(4'b1000));
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
